// File: rtl/if_stage_imem_loader.sv
// Instruction-fetch front end: bench-loadable IMEM, PC register and IF/ID register.
// LOAD streams words into IMEM, RUN fetches one word per cycle, HALT freezes on a fetch fault.
module if_stage_imem_loader #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tb_we,
  input  logic [XLEN-1:0] tb_addr,
  input  logic [31:0]     tb_inst,
  input  logic            tb_start,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic            if_id_valid,
  output logic            running,
  output logic            fetch_err
);

  localparam int unsigned IDX_W  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned WORD_W = XLEN - 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_id_pc_d;
  logic [31:0]     if_id_inst_d;
  logic            if_id_valid_d;
  logic            running_d;
  logic            fetch_err_d;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [WORD_W-1:0] tb_word;
  logic [WORD_W-1:0] pc_word;
  logic              tb_in_range;
  logic              pc_in_range;
  logic [31:0]       fetch_inst;
  logic              unused_addr_bits;

  assign tb_word          = tb_addr[XLEN-1:2];
  assign pc_word          = pc_q[XLEN-1:2];
  assign tb_in_range      = tb_word < WORD_W'(IMEM_DEPTH);
  assign pc_in_range      = pc_word < WORD_W'(IMEM_DEPTH);
  assign fetch_inst       = imem[pc_q[IDX_W+1:2]];
  assign unused_addr_bits = ^tb_addr[1:0];

  // IMEM load port; contents survive reset so a program can be restarted.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_LOAD && tb_we && tb_in_range) begin
      imem[tb_addr[IDX_W+1:2]] <= tb_inst;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc;
    if_id_inst_d  = if_id_inst;
    if_id_valid_d = if_id_valid;
    fetch_err_d   = fetch_err;

    case (state_q)
      S_LOAD: begin
        if (tb_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect_en) begin
          if (redirect_pc[1:0] != 2'b00) begin
            state_d       = S_HALT;
            fetch_err_d   = 1'b1;
            if_id_valid_d = 1'b0;
          end else begin
            pc_d          = redirect_pc;
            if_id_inst_d  = NOP;
            if_id_valid_d = 1'b0;
          end
        end else if (!stall) begin
          if (!pc_in_range) begin
            state_d       = S_HALT;
            fetch_err_d   = 1'b1;
            if_id_valid_d = 1'b0;
          end else begin
            if_id_pc_d    = pc_q;
            if_id_inst_d  = fetch_inst;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + XLEN'(4);
          end
        end
      end
      S_HALT: begin
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    running_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      pc_q        <= RESET_PC;
      if_id_pc    <= '0;
      if_id_inst  <= NOP;
      if_id_valid <= 1'b0;
      running     <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_id_pc    <= if_id_pc_d;
      if_id_inst  <= if_id_inst_d;
      if_id_valid <= if_id_valid_d;
      running     <= running_d;
      fetch_err   <= fetch_err_d;
    end
  end

endmodule
